// File: rtl/cpe_cpu_pkg.sv
// Shared CPU definitions: condition-flag bit positions, flag vector type and
// the flag-readiness state encoding used by status_flags_unit.
package cpe_cpu_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

    typedef logic [FLAG_W-1:0] flags_t;

    typedef enum logic {
        ST_READY   = 1'b0,
        ST_PENDING = 1'b1
    } flag_state_e;

endpackage

// File: rtl/flag_pend_counter.sv
// Saturating up/down counter of in-flight flag writers with synchronous clear.
// zero_o reports the next count value so the owner can register readiness with it.
module flag_pend_counter #(
    parameter int MAX_COUNT = 3,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o,
    output logic             ovf_err_o,
    output logic             unf_err_o
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] count_q, count_d;
    logic             dec_ok, inc_ok;

    always_comb begin
        unf_err_o = dec_i && (count_q == '0);
        dec_ok    = dec_i && !unf_err_o;
        // a simultaneous legal decrement makes room, so a full counter is no overflow then
        ovf_err_o = !clear_i && inc_i && !dec_ok && (count_q == MAX_C);
        inc_ok    = inc_i && !ovf_err_o;
        count_d   = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_ok && !dec_ok) begin
            count_d = count_q + 1'b1;
        end else if (dec_ok && !inc_ok) begin
            count_d = count_q - 1'b1;
        end
        zero_o = (count_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/status_flags_unit.sv
// Condition-flag register with pending-writer tracking and a one-level shadow.
// Optional build macro FLAG_FORWARD_EN forwards the final flag update combinationally.
module status_flags_unit #(
    parameter int FLAG_W      = cpe_cpu_pkg::FLAG_W,
    parameter int MAX_PENDING = 3,
    parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_setf,
    input  logic              alu_flags_valid,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [FLAG_W-1:0] wr_data,
    input  logic              save,
    input  logic              restore,
    output logic [FLAG_W-1:0] flags_out,
    output logic              flags_ready,
    output logic [CNT_W-1:0]  pend_cnt,
    output logic              proto_err
);
    import cpe_cpu_pkg::*;

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [FLAG_W-1:0] shadow_q, shadow_d;
    logic              shadow_valid_q, shadow_valid_d;
    logic              proto_err_q, proto_err_d;
    flag_state_e       state_q, state_d;
    logic              cnt_zero_next, ovf_err, unf_err;
    logic              retire_ok, restore_ok;

    flag_pend_counter #(
        .MAX_COUNT (MAX_PENDING),
        .CNT_W     (CNT_W)
    ) u_pend (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (flush),
        .inc_i     (issue_setf),
        .dec_i     (alu_flags_valid),
        .count_o   (pend_cnt),
        .zero_o    (cnt_zero_next),
        .ovf_err_o (ovf_err),
        .unf_err_o (unf_err)
    );

    always_comb begin
        restore_ok = restore && shadow_valid_q;
        retire_ok  = alu_flags_valid && !unf_err;

        flags_d = flags_q;
        if (restore_ok) begin
            flags_d = shadow_q;
        end else if (wr_en) begin
            flags_d = wr_data;
        end else if (retire_ok) begin
            flags_d = alu_flags;
        end

        // save always captures the pre-update flags, which also yields the swap case
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        if (save) begin
            shadow_d       = flags_q;
            shadow_valid_d = 1'b1;
        end else if (restore) begin
            shadow_valid_d = 1'b0;
        end

        proto_err_d = proto_err_q || ovf_err || unf_err || (restore && !shadow_valid_q);
        state_d     = cnt_zero_next ? ST_READY : ST_PENDING;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q        <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            proto_err_q    <= 1'b0;
            state_q        <= ST_READY;
        end else begin
            flags_q        <= flags_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            proto_err_q    <= proto_err_d;
            state_q        <= state_d;
        end
    end

    assign proto_err = proto_err_q;

`ifdef FLAG_FORWARD_EN
    logic flag_upd;
    assign flag_upd = restore_ok || wr_en || retire_ok;

    always_comb begin
        flags_out   = flags_q;
        flags_ready = (state_q == ST_READY);
        if (!rst && cnt_zero_next && flag_upd) begin
            flags_out   = flags_d;
            flags_ready = 1'b1;
        end
    end
`else
    assign flags_out   = flags_q;
    assign flags_ready = (state_q == ST_READY);
`endif

endmodule

// File: tb/tb_status_flags_unit.sv
// Bench for status_flags_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_status_flags_unit;

    localparam int MAXP = 3;

    logic       clk = 1'b0;
    logic       rst, issue_setf, alu_flags_valid, flush, wr_en, save, restore;
    logic [3:0] alu_flags, wr_data;
    logic [3:0] flags_out;
    logic       flags_ready, proto_err;
    logic [1:0] pend_cnt;

    int checks = 0;
    int errors = 0;

    // behavioural model state and its next values
    int         m_pend, n_pend;
    logic [3:0] m_flags, n_flags, m_shadow, n_shadow;
    logic       m_sv, n_sv, m_err, n_err, n_upd;

    status_flags_unit dut (
        .clk             (clk),
        .rst             (rst),
        .issue_setf      (issue_setf),
        .alu_flags_valid (alu_flags_valid),
        .alu_flags       (alu_flags),
        .flush           (flush),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .save            (save),
        .restore         (restore),
        .flags_out       (flags_out),
        .flags_ready     (flags_ready),
        .pend_cnt        (pend_cnt),
        .proto_err       (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 0; issue_setf = 0; alu_flags_valid = 0; flush = 0;
        wr_en = 0; save = 0; restore = 0; alu_flags = '0; wr_data = '0;
    endtask

    task automatic model_next();
        logic ret;
        ret     = alu_flags_valid && (m_pend > 0);
        n_err   = m_err;
        if (alu_flags_valid && m_pend == 0) n_err = 1;
        if (flush) begin
            n_pend = 0;
        end else begin
            n_pend = m_pend + int'(issue_setf) - int'(ret);
            if (n_pend > MAXP) begin
                n_pend = MAXP;
                n_err  = 1;
            end
        end
        if (restore && !m_sv) n_err = 1;
        n_flags = m_flags;
        n_upd   = 1;
        if (restore && m_sv)  n_flags = m_shadow;
        else if (wr_en)       n_flags = wr_data;
        else if (ret)         n_flags = alu_flags;
        else                  n_upd = 0;
        n_shadow = m_shadow;
        n_sv     = m_sv;
        if (save) begin
            n_shadow = m_flags;
            n_sv     = 1;
        end else if (restore) begin
            n_sv = 0;
        end
        if (rst) begin
            n_pend = 0; n_flags = 0; n_shadow = 0; n_sv = 0; n_err = 0; n_upd = 0;
        end
    endtask

    // one clock: compare at the falling edge, advance the model at the rising edge
    task automatic tick();
        logic [3:0] exp_f;
        logic       exp_r;
        @(negedge clk);
        model_next();
        exp_f = m_flags;
        exp_r = (m_pend == 0);
`ifdef FLAG_FORWARD_EN
        if (n_pend == 0 && n_upd) begin
            exp_f = n_flags;
            exp_r = 1;
        end
`endif
        chk("flags_out", 32'(flags_out), 32'(exp_f));
        chk("flags_ready", 32'(flags_ready), 32'(exp_r));
        chk("pend_cnt", 32'(pend_cnt), 32'(m_pend));
        chk("proto_err", 32'(proto_err), 32'(m_err));
        @(posedge clk);
        m_pend = n_pend; m_flags = n_flags; m_shadow = n_shadow; m_sv = n_sv; m_err = n_err;
        #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); tick(); rst = 0;
    endtask

    initial begin
        m_pend = 0; m_flags = 0; m_shadow = 0; m_sv = 0; m_err = 0;
        idle();
        rst = 1;
        @(posedge clk); #1;
        tick(); rst = 0;
        chk("t1_flags", 32'(flags_out), 32'h0);
        chk("t1_ready", 32'(flags_ready), 32'h1);
        chk("t1_pend", 32'(pend_cnt), 32'h0);
        chk("t1_err", 32'(proto_err), 32'h0);

        idle(); issue_setf = 1; tick(); tick();
        chk("t2_pend2", 32'(pend_cnt), 32'h2);
        idle(); alu_flags_valid = 1; alu_flags = 4'b0001; tick();
        chk("t2_pend1", 32'(pend_cnt), 32'h1);
        chk("t2_notready", 32'(flags_ready), 32'h0);
        idle(); alu_flags_valid = 1; alu_flags = 4'b1000; tick();
        chk("t2_pend0", 32'(pend_cnt), 32'h0);
        chk("t2_flags", 32'(flags_out), 32'h8);
        chk("t2_ready", 32'(flags_ready), 32'h1);

        idle(); issue_setf = 1; tick(); tick();
        idle(); flush = 1; issue_setf = 1; alu_flags_valid = 1; alu_flags = 4'b0100; tick();
        chk("t3_pend", 32'(pend_cnt), 32'h0);
        chk("t3_flags", 32'(flags_out), 32'h4);
        chk("t3_err", 32'(proto_err), 32'h0);

        idle(); wr_en = 1; wr_data = 4'b0011; tick();
        idle(); save = 1; tick();
        idle(); wr_en = 1; wr_data = 4'b1100; tick();
        chk("t4_wr", 32'(flags_out), 32'hC);
        idle(); restore = 1; tick();
        chk("t4_restore", 32'(flags_out), 32'h3);
        chk("t4_err0", 32'(proto_err), 32'h0);
        idle(); restore = 1; tick();
        chk("t4_sv_cleared", 32'(proto_err), 32'h1);
        chk("t4_flags_kept", 32'(flags_out), 32'h3);
        do_reset();

        idle(); wr_en = 1; wr_data = 4'b0101; tick();
        idle(); save = 1; tick();
        idle(); wr_en = 1; wr_data = 4'b1010; tick();
        idle(); save = 1; restore = 1; tick();
        chk("t5_swap", 32'(flags_out), 32'h5);
        idle(); restore = 1; tick();
        chk("t5_restore", 32'(flags_out), 32'hA);
        chk("t5_err", 32'(proto_err), 32'h0);

        idle(); issue_setf = 1; tick(); tick(); tick(); tick();
        chk("t6_pend_sat", 32'(pend_cnt), 32'h3);
        chk("t6_err", 32'(proto_err), 32'h1);
        idle(); tick(); tick();
        chk("t6_err_sticky", 32'(proto_err), 32'h1);
        do_reset();
        chk("t6_err_rst", 32'(proto_err), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            idle();
            rst             = ($urandom_range(0, 199) == 0);
            issue_setf      = ($urandom_range(0, 99) < 40);
            alu_flags_valid = ($urandom_range(0, 99) < 40);
            alu_flags       = 4'($urandom);
            flush           = ($urandom_range(0, 99) < 3);
            wr_en           = ($urandom_range(0, 99) < 10);
            wr_data         = 4'($urandom);
            save            = ($urandom_range(0, 99) < 8);
            restore         = ($urandom_range(0, 99) < 8);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
